// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_gshare
//  Brief    : Fetch-side PC owner with a gshare-indexed table of saturating
//             counters for conditional branches and a tagged direct-mapped
//             target buffer for JALR. History is updated at commit only.
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor_gshare #(
    parameter int PHT_IDX_W = 7,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 7,
    parameter bit GSHARE_EN = 1'b1,
    parameter int BTB_IDX_W = 4,
    parameter int TAG_W     = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 fetch_new_instruction,
    input  logic [2:0]           op_type,
    input  logic [5:0]           op_in,
    input  logic [31:0]          imm,
    output logic [31:0]          pc_out,
    output logic                 pc_predict,
    output logic [PHT_IDX_W-1:0] pred_idx,
    output logic                 jalr_hit,
    output logic [31:0]          jalr_target,
    output logic                 stop_fetching,
    input  logic                 rob_commit,
    input  logic [31:0]          rob_pc_commit,
    input  logic [5:0]           rob_op_commit,
    input  logic [2:0]           rob_op_type,
    input  logic                 rob_result,
    input  logic [31:0]          rob_pc_result,
    input  logic [PHT_IDX_W-1:0] rob_pred_idx,
    input  logic                 roll_back
);

    // Decoder encodings shared with the instruction-queue decoder.
    localparam logic [2:0] c_TYPE_BRANCH = 3'd1;
    localparam logic [5:0] c_OP_JAL      = 6'd1;
    localparam logic [5:0] c_OP_JALR     = 6'd2;

    localparam int c_PHT_N = 1 << PHT_IDX_W;
    localparam int c_BTB_N = 1 << BTB_IDX_W;

    // Counter thresholds: MSB set means "taken"; reset is just below it.
    localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_CTR_THR  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] c_CTR_INIT = c_CTR_THR - CTR_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]        r_pc;
    logic               r_stop;
    logic [GHR_W-1:0]   r_ghr;
    logic [CTR_W-1:0]   r_pht     [c_PHT_N];
    logic               r_btb_vld [c_BTB_N];
    logic [TAG_W-1:0]   r_btb_tag [c_BTB_N];
    logic [31:0]        r_btb_tgt [c_BTB_N];

    // ------------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------------
    logic [PHT_IDX_W-1:0] w_pc_idx;
    logic [BTB_IDX_W-1:0] w_bidx;
    logic [TAG_W-1:0]     w_tag;

    assign w_pc_idx = r_pc[PHT_IDX_W+1:2];
    assign w_bidx   = r_pc[BTB_IDX_W+1:2];
    assign w_tag    = r_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];

    generate
        if (GSHARE_EN) begin : g_idx_hash
            assign pred_idx = w_pc_idx ^ PHT_IDX_W'(r_ghr);
        end else begin : g_idx_pc
            assign pred_idx = w_pc_idx;
        end
    endgenerate

    assign pc_out        = r_pc;
    assign stop_fetching = r_stop;
    assign pc_predict    = (r_pht[pred_idx] >= c_CTR_THR);
    assign jalr_hit      = r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == w_tag);
    assign jalr_target   = r_btb_tgt[w_bidx];

    // ------------------------------------------------------------------------
    // Commit / rollback side (rollback carries the culprit's update fields)
    // ------------------------------------------------------------------------
    logic                 w_upd;
    logic                 w_br_upd;
    logic                 w_btb_wr;
    logic [BTB_IDX_W-1:0] w_wr_bidx;
    logic [TAG_W-1:0]     w_wr_tag;
    logic [CTR_W-1:0]     w_ctr_old;
    logic [CTR_W-1:0]     w_ctr_new;
    logic [GHR_W-1:0]     w_ghr_nxt;
    logic                 w_unused_pc;

    assign w_upd       = roll_back || rob_commit;
    assign w_br_upd    = w_upd && (rob_op_type == c_TYPE_BRANCH);
    assign w_btb_wr    = w_upd && (rob_op_commit == c_OP_JALR);
    assign w_wr_bidx   = rob_pc_commit[BTB_IDX_W+1:2];
    assign w_wr_tag    = rob_pc_commit[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    assign w_ctr_old   = r_pht[rob_pred_idx];
    assign w_unused_pc = ^rob_pc_commit;

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign w_ghr_nxt = rob_result;
        end else begin : g_ghr_shift
            assign w_ghr_nxt = {r_ghr[GHR_W-2:0], rob_result};
        end
    endgenerate

    // Saturating counter step for the resolved branch.
    always_comb begin
        w_ctr_new = w_ctr_old;
        if (rob_result) begin
            if (w_ctr_old != c_CTR_MAX) w_ctr_new = w_ctr_old + CTR_W'(1);
        end else begin
            if (w_ctr_old != '0) w_ctr_new = w_ctr_old - CTR_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Next PC / stall: fetch first, then commit/rollback override it.
    // ------------------------------------------------------------------------
    logic [31:0] w_pc_nxt;
    logic        w_stop_nxt;

    always_comb begin
        w_pc_nxt   = r_pc;
        w_stop_nxt = r_stop;
        if (fetch_new_instruction && !r_stop) begin
            if (op_in == c_OP_JAL) begin
                w_pc_nxt = r_pc + imm;
            end else if (op_in == c_OP_JALR) begin
                if (jalr_hit) w_pc_nxt = jalr_target;
                else          w_stop_nxt = 1'b1;
            end else if (op_type == c_TYPE_BRANCH) begin
                w_pc_nxt = r_pc + (pc_predict ? imm : 32'd4);
            end else begin
                w_pc_nxt = r_pc + 32'd4;
            end
        end
        if (roll_back) begin
            w_pc_nxt   = rob_pc_result;
            w_stop_nxt = 1'b0;
        end else if (rob_commit && (rob_op_commit == c_OP_JALR) && r_stop) begin
            w_pc_nxt   = rob_pc_result;
            w_stop_nxt = 1'b0;
        end
    end

    // PC, stall flag and global history registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc   <= 32'd0;
            r_stop <= 1'b0;
            r_ghr  <= '0;
        end else if (rdy_in) begin
            r_pc   <= w_pc_nxt;
            r_stop <= w_stop_nxt;
            if (w_br_upd) r_ghr <= w_ghr_nxt;
        end
    end

    // Pattern history table write at branch resolution.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_PHT_N; i++) r_pht[i] <= c_CTR_INIT;
        end else if (rdy_in && w_br_upd) begin
            r_pht[rob_pred_idx] <= w_ctr_new;
        end
    end

    // JALR target buffer fill; a new tag simply replaces the old entry.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_BTB_N; i++) begin
                r_btb_vld[i] <= 1'b0;
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= 32'd0;
            end
        end else if (rdy_in && w_btb_wr) begin
            r_btb_vld[w_wr_bidx] <= 1'b1;
            r_btb_tag[w_wr_bidx] <= w_wr_tag;
            r_btb_tgt[w_wr_bidx] <= rob_pc_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor_gshare
//  Brief    : Table-driven bench for branch_predictor_gshare. Two instances
//             share stimulus: u_dut_p (PC-only index) and u_dut_g (gshare).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor_gshare;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_BR    = 3'd1;
    localparam logic [5:0] OP_NONE = 6'd0;
    localparam logic [5:0] OP_JAL  = 6'd1;
    localparam logic [5:0] OP_JALR = 6'd2;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in, rdy_in, fetch_new_instruction;
    logic [2:0]  op_type, rob_op_type;
    logic [5:0]  op_in, rob_op_commit;
    logic [31:0] imm, rob_pc_commit, rob_pc_result;
    logic        rob_commit, rob_result, roll_back;
    logic [6:0]  rob_pred_idx;

    logic [31:0] pc_p, tgt_p, pc_g, tgt_g;
    logic        pred_p, hit_p, stop_p, pred_g, hit_g, stop_g;
    logic [6:0]  idx_p, idx_g;

    branch_predictor_gshare #(.PHT_IDX_W(7), .CTR_W(2), .GHR_W(7), .GSHARE_EN(1'b0),
                              .BTB_IDX_W(4), .TAG_W(8)) u_dut_p (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_new_instruction(fetch_new_instruction), .op_type(op_type),
        .op_in(op_in), .imm(imm), .pc_out(pc_p), .pc_predict(pred_p),
        .pred_idx(idx_p), .jalr_hit(hit_p), .jalr_target(tgt_p),
        .stop_fetching(stop_p), .rob_commit(rob_commit),
        .rob_pc_commit(rob_pc_commit), .rob_op_commit(rob_op_commit),
        .rob_op_type(rob_op_type), .rob_result(rob_result),
        .rob_pc_result(rob_pc_result), .rob_pred_idx(rob_pred_idx),
        .roll_back(roll_back));

    branch_predictor_gshare #(.PHT_IDX_W(7), .CTR_W(2), .GHR_W(7), .GSHARE_EN(1'b1),
                              .BTB_IDX_W(4), .TAG_W(8)) u_dut_g (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_new_instruction(fetch_new_instruction), .op_type(op_type),
        .op_in(op_in), .imm(imm), .pc_out(pc_g), .pc_predict(pred_g),
        .pred_idx(idx_g), .jalr_hit(hit_g), .jalr_target(tgt_g),
        .stop_fetching(stop_g), .rob_commit(rob_commit),
        .rob_pc_commit(rob_pc_commit), .rob_op_commit(rob_op_commit),
        .rob_op_type(rob_op_type), .rob_result(rob_result),
        .rob_pc_result(rob_pc_result), .rob_pred_idx(rob_pred_idx),
        .roll_back(roll_back));

    typedef struct {
        logic        rst, rdy, fetch;
        logic [2:0]  op_type;
        logic [5:0]  op;
        logic [31:0] imm;
        logic        commit;
        logic [5:0]  rop;
        logic [2:0]  rtype;
        logic        rres;
        logic [31:0] rpc_c, rpc_r;
        logic [6:0]  ridx;
        logic        rb;
        logic [31:0] e_pc;
        logic        e_stop, e_pred, e_hit;
        logic        chk_g;
        logic [6:0]  e_gidx;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        stop, pred, hit;
        logic [6:0]  idx;
        logic        chk_g;
        logic [6:0]  gidx;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur      = 0;

    function automatic vec_t v_idle();
        vec_t v;
        v = '{default: '0};
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_fetch(logic [5:0] op, logic [2:0] typ, logic [31:0] im);
        vec_t v = v_idle();
        v.fetch = 1'b1; v.op = op; v.op_type = typ; v.imm = im;
        return v;
    endfunction

    function automatic vec_t v_cbr(logic res, logic [6:0] idx);
        vec_t v = v_idle();
        v.commit = 1'b1; v.rtype = T_BR; v.rop = OP_NONE; v.rres = res; v.ridx = idx;
        return v;
    endfunction

    function automatic vec_t v_cjalr(logic [31:0] pcc, logic [31:0] pcr);
        vec_t v = v_idle();
        v.commit = 1'b1; v.rop = OP_JALR; v.rpc_c = pcc; v.rpc_r = pcr;
        return v;
    endfunction

    function automatic vec_t v_rb(vec_t b, logic [31:0] pcr);
        vec_t v = b;
        v.rb = 1'b1; v.rpc_r = pcr;
        return v;
    endfunction

    function automatic vec_t ex(vec_t b, logic [31:0] pc, logic st, logic pr, logic ht);
        vec_t v = b;
        v.e_pc = pc; v.e_stop = st; v.e_pred = pr; v.e_hit = ht;
        return v;
    endfunction

    function automatic vec_t gx(vec_t b, logic [6:0] gidx);
        vec_t v = b;
        v.chk_g = 1'b1; v.e_gidx = gidx;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, cur, act, expv);
        end
    endtask

    // Drive one vector, push its expectation, sample after the edge, compare.
    task automatic apply(vec_t v);
        exp_t e;
        rst_in = v.rst; rdy_in = v.rdy; fetch_new_instruction = v.fetch;
        op_type = v.op_type; op_in = v.op; imm = v.imm;
        rob_commit = v.commit; rob_op_commit = v.rop; rob_op_type = v.rtype;
        rob_result = v.rres; rob_pc_commit = v.rpc_c; rob_pc_result = v.rpc_r;
        rob_pred_idx = v.ridx; roll_back = v.rb;
        e.pc = v.e_pc; e.stop = v.e_stop; e.pred = v.e_pred; e.hit = v.e_hit;
        e.idx = v.e_pc[8:2]; e.chk_g = v.chk_g; e.gidx = v.e_gidx;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        chk("pc_out", pc_p, e.pc);
        chk("stop_fetching", {31'd0, stop_p}, {31'd0, e.stop});
        chk("pc_predict", {31'd0, pred_p}, {31'd0, e.pred});
        chk("jalr_hit", {31'd0, hit_p}, {31'd0, e.hit});
        chk("pred_idx", {25'd0, idx_p}, {25'd0, e.idx});
        if (e.chk_g) chk("gshare_pred_idx", {25'd0, idx_g}, {25'd0, e.gidx});
        cur++;
    endtask

    initial begin
        vec_t r;
        r = v_idle(); r.rst = 1'b1;

        // Reset then three plain fetches.
        tbl.push_back(ex(r, 32'h0, 0, 0, 0));
        tbl.push_back(ex(v_fetch(OP_NONE, T_NONE, 0), 32'h4, 0, 0, 0));
        tbl.push_back(ex(v_fetch(OP_NONE, T_NONE, 0), 32'h8, 0, 0, 0));
        tbl.push_back(ex(v_fetch(OP_NONE, T_NONE, 0), 32'hC, 0, 0, 0));
        // Train counter for pc 0x40 (index 0x10): 1 -> 2 -> 3.
        tbl.push_back(ex(v_cbr(1, 7'h10), 32'hC, 0, 0, 0));
        tbl.push_back(ex(v_cbr(1, 7'h10), 32'hC, 0, 0, 0));
        tbl.push_back(ex(v_rb(v_idle(), 32'h40), 32'h40, 0, 1, 0));
        tbl.push_back(ex(v_fetch(OP_NONE, T_BR, 32'h20), 32'h60, 0, 0, 0));
        // Third taken commit alongside a fetch: counter saturates at 3.
        tbl.push_back(ex(v_cbr(1, 7'h10), 32'h60, 0, 0, 0));
        tbl[$].fetch = 1'b1; tbl[$].e_pc = 32'h64;
        tbl.push_back(ex(v_rb(v_idle(), 32'h40), 32'h40, 0, 1, 0));
        // Four not-taken: 2,1,0,0 then taken twice: 1,2.
        tbl.push_back(ex(v_cbr(0, 7'h10), 32'h40, 0, 1, 0));
        tbl.push_back(ex(v_cbr(0, 7'h10), 32'h40, 0, 0, 0));
        tbl.push_back(ex(v_cbr(0, 7'h10), 32'h40, 0, 0, 0));
        tbl.push_back(ex(v_cbr(0, 7'h10), 32'h40, 0, 0, 0));
        tbl.push_back(ex(v_cbr(1, 7'h10), 32'h40, 0, 0, 0));
        tbl.push_back(ex(v_cbr(1, 7'h10), 32'h40, 0, 1, 0));
        // JALR cold miss, stall, resolve, then hit.
        tbl.push_back(ex(v_rb(v_idle(), 32'h100), 32'h100, 0, 0, 0));
        tbl.push_back(ex(v_fetch(OP_JALR, T_NONE, 0), 32'h100, 1, 0, 0));
        tbl.push_back(ex(v_fetch(OP_NONE, T_NONE, 0), 32'h100, 1, 0, 0));
        tbl.push_back(ex(v_cjalr(32'h100, 32'h2000), 32'h2000, 0, 0, 0));
        tbl.push_back(ex(v_rb(v_idle(), 32'h100), 32'h100, 0, 0, 1));
        tbl.push_back(ex(v_fetch(OP_JALR, T_NONE, 0), 32'h2000, 0, 0, 0));
        // Aliasing: 0x2000 shares entry 0 with 0x100 and replaces it.
        tbl.push_back(ex(v_cjalr(32'h2000, 32'h3000), 32'h2000, 0, 0, 1));
        tbl.push_back(ex(v_fetch(OP_JALR, T_NONE, 0), 32'h3000, 0, 0, 0));
        tbl.push_back(ex(v_rb(v_idle(), 32'h100), 32'h100, 0, 0, 0));
        // Rollback beats a same-cycle JAL fetch.
        tbl.push_back(ex(v_rb(v_fetch(OP_JAL, T_NONE, 32'h8), 32'h80), 32'h80, 0, 0, 0));
        tbl.push_back(ex(v_fetch(OP_JALR, T_NONE, 0), 32'h80, 1, 0, 0));
        tbl.push_back(ex(v_rb(v_idle(), 32'h200), 32'h200, 0, 0, 0));
        // rdy low: fetch, BTB write and counter update all suppressed.
        tbl.push_back(ex(v_cjalr(32'h200, 32'h4000), 32'h200, 0, 0, 0));
        tbl[$].rdy = 1'b0; tbl[$].fetch = 1'b1;
        tbl.push_back(ex(v_cbr(1, 7'h00), 32'h200, 0, 0, 0));
        tbl[$].rdy = 1'b0;
        tbl.push_back(ex(v_cbr(1, 7'h00), 32'h200, 0, 0, 0));
        tbl[$].rdy = 1'b0;
        // Stall, then reset (with rdy low) clears it.
        tbl.push_back(ex(v_fetch(OP_JALR, T_NONE, 0), 32'h200, 1, 0, 0));
        tbl.push_back(ex(r, 32'h0, 0, 0, 0));
        tbl[$].rdy = 1'b0;
        tbl.push_back(ex(v_fetch(OP_NONE, T_NONE, 0), 32'h4, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Global history sequence on the gshare instance.
        apply(ex(r, 32'h0, 0, 0, 0));
        apply(ex(v_cbr(1, 7'h01), 32'h0, 0, 0, 0));
        apply(ex(v_cbr(1, 7'h02), 32'h0, 0, 0, 0));
        apply(ex(v_cbr(0, 7'h03), 32'h0, 0, 0, 0));
        apply(gx(ex(v_rb(v_idle(), 32'h40), 32'h40, 0, 0, 0), 7'h16));
        apply(gx(ex(v_cbr(1, 7'h05), 32'h40, 0, 0, 0), 7'h1D));
        begin
            vec_t v = v_cbr(1, 7'h05);
            v.rdy = 1'b0;
            apply(gx(ex(v, 32'h40, 0, 0, 0), 7'h1D));
        end
        // Rollback of a not-taken branch still shifts history: 0x1A.
        begin
            vec_t v = v_rb(v_cbr(0, 7'h06), 32'h40);
            v.commit = 1'b0;
            apply(gx(ex(v, 32'h40, 0, 0, 0), 7'h0A));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
